// File: rtl/vic_prio_wb.sv
// Vectored interrupt controller: N request channels with masking, edge or level latching,
// and fixed or round-robin priority. Answers the acknowledge strobe with the winner's vector.
module vic_prio_wb #(
  parameter int unsigned N       = 2,
  parameter bit          EDGE    = 1'b1,
  parameter bit          ROTATE  = 1'b0,
  parameter logic [15:0] DEF_VEC = 16'o0
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            ce,
  input  logic [16*N-1:0] ivec,
  input  logic [N-1:0]    ireq,
  input  logic [N-1:0]    imask,
  output logic [N-1:0]    iack,
  input  logic            wb_stb_i,
  output logic [15:0]     wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_irq_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    pend_q, pend_d;
  logic [N-1:0]    ireq_q;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [N-1:0]    iack_q, iack_d;
  logic [15:0]     dat_q, dat_d;
  logic            ack_q, ack_d;
  logic            irq_q, irq_d;
  logic [N-1:0]    elig_s;
  logic [N-1:0]    clr_s;
  logic [N-1:0]    grant_s;
  logic [PW:0]     pick_s;
  logic            found_s;
  logic [PW-1:0]   win_s;

  // Scan from base-1 downward (wrapping), so channel 'base' has the lowest priority.
  function automatic logic [PW:0] pick_winner(input logic [N-1:0] el, input int unsigned base);
    logic [PW:0] r;
    int unsigned idx;
    r = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (base + N - k) % N;
      r   = (!r[PW] && (|(el & (N'(1'b1) << idx)))) ? {1'b1, idx[PW-1:0]} : r;
    end
    return r;
  endfunction

  // Eligible set and priority winner for the current tick.
  always_comb begin
    elig_s  = pend_q & ~imask;
    pick_s  = pick_winner(elig_s, ROTATE ? 32'(ptr_q) : 32'd0);
    found_s = pick_s[PW];
    win_s   = pick_s[PW-1:0];
    grant_s = N'(1'b1) << win_s;
  end

  // Acknowledge FSM, pending update and irq next-state.
  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    ack_d   = ack_q;
    iack_d  = '0;
    ptr_d   = ptr_q;
    clr_s   = '0;
    case (state_q)
      S_IDLE: begin
        if (wb_stb_i) begin
          state_d = S_ACK;
          ack_d   = 1'b1;
          if (found_s) begin
            dat_d  = 16'(ivec >> {win_s, 4'd0});
            iack_d = grant_s;
            clr_s  = grant_s;
            ptr_d  = win_s;
          end else begin
            dat_d  = DEF_VEC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACK: begin
        if (!wb_stb_i) begin
          state_d = S_DROP;
        end else begin
          state_d = S_ACK;
        end
      end
      S_DROP: begin
        ack_d   = 1'b0;
        dat_d   = 16'd0;
        state_d = S_IDLE;
      end
      default: begin
        ack_d   = 1'b0;
        dat_d   = 16'd0;
        state_d = S_IDLE;
      end
    endcase
    // A fresh edge on the grant tick wins over the grant clear.
    pend_d = EDGE ? ((pend_q & ~clr_s) | (ireq & ~ireq_q)) : ireq;
    irq_d  = (state_q == S_IDLE) ? (|elig_s) : 1'b0;
  end

  // State registers; everything except reset advances only on ce.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      ireq_q  <= '0;
      ptr_q   <= '0;
      iack_q  <= '0;
      dat_q   <= 16'd0;
      ack_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ireq_q  <= ireq;
      ptr_q   <= ptr_d;
      iack_q  <= iack_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      irq_q   <= irq_d;
    end
  end

  assign iack     = iack_q;
  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_irq_o = irq_q;

endmodule
